// File: rtl/motor_ramp_guard.sv
// Motor speed ramp limiter with host-alive watchdog: each channel slews toward
// its captured target, and a silent host forces a controlled ramp to stop.
module motor_ramp_guard #(
    parameter int STEP_DIV      = 16000,
    parameter int STEP          = 1,
    parameter int TIMEOUT_TICKS = 500
) (
    input  logic       clk_16mhz,
    input  logic       rst_n,
    input  logic [7:0] speedA_in,
    input  logic [7:0] speedB_in,
    input  logic       alive_toggle,
    output logic [7:0] speedA_out,
    output logic [7:0] speedB_out,
    output logic       aliveStrobe,
    output logic [1:0] state,
    output logic       timeout
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STOP = 2'b10} state_t;

    localparam logic [15:0]        DIV_LAST = 16'(STEP_DIV - 1);
    localparam logic [15:0]        WD_LAST  = 16'(TIMEOUT_TICKS - 1);
    localparam logic signed [8:0]  STEP_LIM = 9'(STEP);

    state_t            fsm;
    logic              sync1, sync2, hist;
    logic [2:0]        fill;
    logic [15:0]       presc, wd;
    logic signed [7:0] tgt_a, tgt_b, out_a, out_b;
    logic signed [7:0] nxt_a, nxt_b;
    logic              upd, tick;

    function automatic logic signed [7:0] sat_in(input logic [7:0] raw);
        logic signed [7:0] v;
        v = raw;
        return (raw == 8'h80) ? 8'sh81 : v;
    endfunction

    function automatic logic signed [7:0] ramp(input logic signed [7:0] cur,
                                               input logic signed [7:0] tgt);
        logic signed [8:0] diff;
        logic signed [8:0] sum;
        diff = $signed({tgt[7], tgt}) - $signed({cur[7], cur});
        if (diff > STEP_LIM)
            diff = STEP_LIM;
        else if (diff < -STEP_LIM)
            diff = -STEP_LIM;
        sum = $signed({cur[7], cur}) + diff;
        return sum[7:0];
    endfunction

    // fill masks the compare until hist holds a sample taken after reset release,
    // so a toggle level held through reset never looks like an update.
    assign upd   = fill[2] & (sync2 ^ hist);
    assign tick  = (presc == DIV_LAST);
    assign nxt_a = ramp(out_a, tgt_a);
    assign nxt_b = ramp(out_b, tgt_b);

    assign speedA_out = out_a;
    assign speedB_out = out_b;
    assign state      = fsm;

    always_ff @(posedge clk_16mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            hist        <= 1'b0;
            fill        <= '0;
            presc       <= '0;
            wd          <= '0;
            tgt_a       <= '0;
            tgt_b       <= '0;
            out_a       <= '0;
            out_b       <= '0;
            aliveStrobe <= 1'b0;
            timeout     <= 1'b0;
            fsm         <= IDLE;
        end else begin
            sync1 <= alive_toggle;
            sync2 <= sync1;
            hist  <= sync2;
            fill  <= {fill[1:0], 1'b1};
            presc <= tick ? '0 : presc + 16'd1;

            // Steps use the targets held before this edge; a same-cycle update lands next tick.
            if (tick) begin
                out_a <= nxt_a;
                out_b <= nxt_b;
                if (fsm != IDLE)
                    aliveStrobe <= ~aliveStrobe;
            end

            if (upd) begin
                fsm     <= RUN;
                tgt_a   <= sat_in(speedA_in);
                tgt_b   <= sat_in(speedB_in);
                wd      <= '0;
                timeout <= 1'b0;
            end else begin
                case (fsm)
                    RUN: begin
                        if (tick) begin
                            if (wd == WD_LAST) begin
                                fsm     <= STOP;
                                tgt_a   <= '0;
                                tgt_b   <= '0;
                                wd      <= '0;
                                timeout <= 1'b1;
                            end else begin
                                wd <= wd + 16'd1;
                            end
                        end
                    end
                    STOP: begin
                        if (tick && nxt_a == 8'sd0 && nxt_b == 8'sd0)
                            fsm <= IDLE;
                    end
                    IDLE: begin
                    end
                    default: fsm <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_motor_ramp_guard.sv
// Bench for motor_ramp_guard: directed ramp/timeout/collision/reset vectors plus
// randomized host traffic compared each cycle against an arithmetic reference model.
module tb_motor_ramp_guard;
    localparam int STEP_DIV      = 4;
    localparam int STEP          = 1;
    localparam int TIMEOUT_TICKS = 8;
    localparam int NVEC          = 37;

    logic       clk_16mhz = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] speedA_in = 8'h00;
    logic [7:0] speedB_in = 8'h00;
    logic       alive_toggle = 1'b0;
    logic [7:0] speedA_out, speedB_out;
    logic       aliveStrobe;
    logic [1:0] state;
    logic       timeout;

    logic [7:0] sat_a_in = 8'h00;
    logic [7:0] sat_b_in = 8'h00;
    logic       sat_toggle = 1'b0;
    logic [7:0] sat_a_out, sat_b_out;
    logic       sat_strobe;
    logic [1:0] sat_state;
    logic       sat_timeout;

    int checks = 0;
    int failures = 0;

    motor_ramp_guard #(.STEP_DIV(STEP_DIV), .STEP(STEP), .TIMEOUT_TICKS(TIMEOUT_TICKS)) dut (
        .clk_16mhz(clk_16mhz), .rst_n(rst_n),
        .speedA_in(speedA_in), .speedB_in(speedB_in), .alive_toggle(alive_toggle),
        .speedA_out(speedA_out), .speedB_out(speedB_out), .aliveStrobe(aliveStrobe),
        .state(state), .timeout(timeout)
    );

    motor_ramp_guard #(.STEP_DIV(STEP_DIV), .STEP(127), .TIMEOUT_TICKS(TIMEOUT_TICKS)) u_sat (
        .clk_16mhz(clk_16mhz), .rst_n(rst_n),
        .speedA_in(sat_a_in), .speedB_in(sat_b_in), .alive_toggle(sat_toggle),
        .speedA_out(sat_a_out), .speedB_out(sat_b_out), .aliveStrobe(sat_strobe),
        .state(sat_state), .timeout(sat_timeout)
    );

    always #5 clk_16mhz = ~clk_16mhz;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: update fires on the 3rd edge after a toggle change,
    // step ticks land on every STEP_DIV-th edge after reset release.
    int m_edges = 0;
    bit tq[$];
    int m_st = 0, m_tgt_a = 0, m_tgt_b = 0, m_out_a = 0, m_out_b = 0, m_wd = 0;
    bit m_strobe = 0, m_to = 0, m_upd = 0, m_tick = 0;
    bit chk_en = 0;

    function automatic int cap(input logic [7:0] raw);
        int v;
        v = int'($signed(raw));
        return (v == -128) ? -127 : v;
    endfunction

    function automatic int approach(input int cur, input int tgt, input int lim);
        int d;
        d = tgt - cur;
        if (d > lim) d = lim;
        if (d < -lim) d = -lim;
        return cur + d;
    endfunction

    initial begin
        forever begin
            @(posedge clk_16mhz or negedge rst_n);
            if (!rst_n) begin
                m_edges = 0; tq.delete();
                m_st = 0; m_tgt_a = 0; m_tgt_b = 0; m_out_a = 0; m_out_b = 0;
                m_wd = 0; m_strobe = 0; m_to = 0;
            end else begin
                m_edges++;
                tq.push_back(alive_toggle);
                if (tq.size() > 4) void'(tq.pop_front());
                m_upd  = (m_edges >= 4) && (tq[0] != tq[1]);
                m_tick = (m_edges % STEP_DIV) == 0;
                if (m_tick) begin
                    m_out_a = approach(m_out_a, m_tgt_a, STEP);
                    m_out_b = approach(m_out_b, m_tgt_b, STEP);
                    if (m_st != 0) m_strobe = ~m_strobe;
                end
                if (m_upd) begin
                    m_st = 1; m_tgt_a = cap(speedA_in); m_tgt_b = cap(speedB_in);
                    m_wd = 0; m_to = 0;
                end else if (m_st == 1 && m_tick) begin
                    m_wd++;
                    if (m_wd >= TIMEOUT_TICKS) begin
                        m_st = 2; m_tgt_a = 0; m_tgt_b = 0; m_to = 1; m_wd = 0;
                    end
                end else if (m_st == 2 && m_tick && m_out_a == 0 && m_out_b == 0) begin
                    m_st = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_16mhz);
            if (chk_en && rst_n)
                check("model", int'({speedA_out, speedB_out, aliveStrobe, state, timeout}),
                      int'({8'(m_out_a), 8'(m_out_b), m_strobe, 2'(m_st), m_to}));
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL sim_time_limit actual=expired required=finish");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic [7:0] a_in;
        logic [7:0] b_in;
        bit         tog;
        int         exp_a;
        int         exp_b;
        int         exp_st;
        bit         exp_to;
        bit         flip;
    } vec_t;
    vec_t tbl[NVEC];
    logic prev_strobe;

    task automatic next_tick();
        do begin
            @(posedge clk_16mhz); #1;
        end while ((m_edges % STEP_DIV) != 0);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_16mhz); #1;
        end
    endtask

    function automatic logic [7:0] rand_speed();
        int v;
        case ($urandom_range(0, 3))
            0: v = -128;
            1: v = int'($urandom_range(0, 255));
            default: v = int'($urandom_range(0, 12)) - 6;
        endcase
        return 8'(v);
    endfunction

    initial begin
        // ramp-up, reversal, -128 capture, watchdog timeout and revive from IDLE
        tbl[0]  = '{8'h00, 8'h00, 1'b0,  1, -1, 1, 1'b0, 1'b1};
        tbl[1]  = '{8'h00, 8'h00, 1'b0,  2, -2, 1, 1'b0, 1'b1};
        tbl[2]  = '{8'h00, 8'h00, 1'b0,  3, -3, 1, 1'b0, 1'b1};
        tbl[3]  = '{8'h00, 8'h00, 1'b0,  4, -3, 1, 1'b0, 1'b1};
        tbl[4]  = '{8'h00, 8'h00, 1'b0,  5, -3, 1, 1'b0, 1'b1};
        tbl[5]  = '{8'h00, 8'h00, 1'b0,  5, -3, 1, 1'b0, 1'b1};
        tbl[6]  = '{8'h03, 8'hFD, 1'b1,  4, -3, 1, 1'b0, 1'b1};
        tbl[7]  = '{8'h00, 8'h00, 1'b0,  3, -3, 1, 1'b0, 1'b1};
        tbl[8]  = '{8'hFE, 8'h00, 1'b1,  2, -2, 1, 1'b0, 1'b1};
        tbl[9]  = '{8'h00, 8'h00, 1'b0,  1, -1, 1, 1'b0, 1'b1};
        tbl[10] = '{8'h00, 8'h00, 1'b0,  0,  0, 1, 1'b0, 1'b1};
        tbl[11] = '{8'h00, 8'h00, 1'b0, -1,  0, 1, 1'b0, 1'b1};
        tbl[12] = '{8'h00, 8'h00, 1'b0, -2,  0, 1, 1'b0, 1'b1};
        tbl[13] = '{8'h80, 8'h7F, 1'b1, -3,  1, 1, 1'b0, 1'b1};
        tbl[14] = '{8'h00, 8'h00, 1'b0, -4,  2, 1, 1'b0, 1'b1};
        tbl[15] = '{8'h04, 8'h00, 1'b1, -3,  1, 1, 1'b0, 1'b1};
        tbl[16] = '{8'h00, 8'h00, 1'b0, -2,  0, 1, 1'b0, 1'b1};
        tbl[17] = '{8'h00, 8'h00, 1'b0, -1,  0, 1, 1'b0, 1'b1};
        tbl[18] = '{8'h00, 8'h00, 1'b0,  0,  0, 1, 1'b0, 1'b1};
        tbl[19] = '{8'h04, 8'h00, 1'b1,  1,  0, 1, 1'b0, 1'b1};
        tbl[20] = '{8'h00, 8'h00, 1'b0,  2,  0, 1, 1'b0, 1'b1};
        tbl[21] = '{8'h00, 8'h00, 1'b0,  3,  0, 1, 1'b0, 1'b1};
        tbl[22] = '{8'h04, 8'h00, 1'b1,  4,  0, 1, 1'b0, 1'b1};
        tbl[23] = '{8'h00, 8'h00, 1'b0,  4,  0, 1, 1'b0, 1'b1};
        tbl[24] = '{8'h00, 8'h00, 1'b0,  4,  0, 1, 1'b0, 1'b1};
        tbl[25] = '{8'h00, 8'h00, 1'b0,  4,  0, 1, 1'b0, 1'b1};
        tbl[26] = '{8'h00, 8'h00, 1'b0,  4,  0, 1, 1'b0, 1'b1};
        tbl[27] = '{8'h00, 8'h00, 1'b0,  4,  0, 1, 1'b0, 1'b1};
        tbl[28] = '{8'h00, 8'h00, 1'b0,  4,  0, 1, 1'b0, 1'b1};
        tbl[29] = '{8'h00, 8'h00, 1'b0,  4,  0, 2, 1'b1, 1'b1};
        tbl[30] = '{8'h00, 8'h00, 1'b0,  3,  0, 2, 1'b1, 1'b1};
        tbl[31] = '{8'h00, 8'h00, 1'b0,  2,  0, 2, 1'b1, 1'b1};
        tbl[32] = '{8'h00, 8'h00, 1'b0,  1,  0, 2, 1'b1, 1'b1};
        tbl[33] = '{8'h00, 8'h00, 1'b0,  0,  0, 0, 1'b1, 1'b1};
        tbl[34] = '{8'h00, 8'h00, 1'b0,  0,  0, 0, 1'b1, 1'b0};
        tbl[35] = '{8'h02, 8'h00, 1'b1,  1,  0, 1, 1'b0, 1'b1};
        tbl[36] = '{8'h00, 8'h00, 1'b0,  2,  0, 1, 1'b0, 1'b1};

        #3 rst_n = 1'b0;
        #1;
        check("rst_a", int'(speedA_out), 0);
        check("rst_b", int'(speedB_out), 0);
        check("rst_strobe", int'(aliveStrobe), 0);
        check("rst_state", int'(state), 0);
        check("rst_timeout", int'(timeout), 0);
        alive_toggle = 1'b1;
        speedA_in = 8'd40;
        cycles(3);
        @(posedge clk_16mhz); #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        cycles(12);
        check("no_update_after_reset", int'(state), 0);

        // Ramp-up: update lands on the third edge after the toggle.
        next_tick();
        speedA_in = 8'd5;
        speedB_in = 8'hFD;
        alive_toggle = ~alive_toggle;
        cycles(2);
        check("run_latency_edge2", int'(state), 0);
        cycles(1);
        check("run_latency_edge3", int'(state), 1);

        for (int i = 0; i < NVEC; i++) begin
            prev_strobe = aliveStrobe;
            if (tbl[i].tog) begin
                speedA_in = tbl[i].a_in;
                speedB_in = tbl[i].b_in;
                alive_toggle = ~alive_toggle;
            end
            next_tick();
            check($sformatf("vec%0d_a", i), int'($signed(speedA_out)), tbl[i].exp_a);
            check($sformatf("vec%0d_b", i), int'($signed(speedB_out)), tbl[i].exp_b);
            check($sformatf("vec%0d_state", i), int'(state), tbl[i].exp_st);
            check($sformatf("vec%0d_timeout", i), int'(timeout), int'(tbl[i].exp_to));
            check($sformatf("vec%0d_strobe", i), int'(aliveStrobe), int'(prev_strobe ^ tbl[i].flip));
        end

        // Collision: update event lands on the watchdog's 8th tick.
        speedA_in = 8'd2;
        speedB_in = 8'd0;
        alive_toggle = ~alive_toggle;
        next_tick();
        for (int i = 0; i < 6; i++) next_tick();
        @(posedge clk_16mhz); #1;
        alive_toggle = ~alive_toggle;
        next_tick();
        check("collision_state", int'(state), 1);
        check("collision_timeout", int'(timeout), 0);
        for (int i = 0; i < 7; i++) next_tick();
        check("wd_restart_7", int'(state), 1);
        next_tick();
        check("wd_restart_8_state", int'(state), 2);
        check("wd_restart_8_timeout", int'(timeout), 1);
        check("wd_restart_8_a", int'($signed(speedA_out)), 2);
        next_tick();
        check("stop_ramp_a", int'($signed(speedA_out)), 1);
        next_tick();
        check("stop_to_idle", int'(state), 0);

        // Asynchronous reset mid-ramp.
        speedA_in = 8'd5;
        alive_toggle = ~alive_toggle;
        for (int i = 0; i < 3; i++) next_tick();
        check("midramp_a", int'($signed(speedA_out)), 3);
        @(negedge clk_16mhz); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_a", int'(speedA_out), 0);
        check("async_rst_state", int'(state), 0);
        check("async_rst_strobe", int'(aliveStrobe), 0);
        cycles(2);
        rst_n = 1'b1;

        // Saturation with STEP=127.
        next_tick();
        sat_a_in = 8'h80;
        sat_toggle = ~sat_toggle;
        next_tick();
        check("sat_neg", int'($signed(sat_a_out)), -127);
        next_tick();
        check("sat_neg_hold", int'($signed(sat_a_out)), -127);
        sat_a_in = 8'h7F;
        sat_toggle = ~sat_toggle;
        next_tick();
        check("sat_mid", int'($signed(sat_a_out)), 0);
        next_tick();
        check("sat_pos", int'($signed(sat_a_out)), 127);

        // Randomized host traffic alternating between busy and sparse update rates.
        for (int blk = 0; blk < 10; blk++) begin
            int rate;
            rate = (blk % 2 == 0) ? 8 : 60;
            for (int c = 0; c < 400; c++) begin
                @(posedge clk_16mhz); #1;
                if ($urandom_range(0, rate - 1) == 0) begin
                    speedA_in = rand_speed();
                    speedB_in = rand_speed();
                    alive_toggle = ~alive_toggle;
                end
            end
        end

        @(negedge clk_16mhz);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
